// File: rtl/exec_cnt_pkg.sv
// Shared definitions for the local-bus config path: command codes, config
// addresses and the measurement FSM states.
package exec_cnt_pkg;

  localparam logic [7:0] CMD_READ         = 8'h00;
  localparam logic [7:0] CMD_WRITE        = 8'h01;
  localparam logic [7:0] CMD_CONFIG_READ  = 8'h02;
  localparam logic [7:0] CMD_CONFIG_WRITE = 8'h03;

  localparam logic [15:0] ADDR_CNT0 = 16'h0005;
  localparam logic [15:0] ADDR_CNT1 = 16'h0006;
  localparam logic [15:0] ADDR_CTRL = 16'h0007;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/exec_time_counter_if.sv
// Local-bus command path, core start/done pulses and measurement results of
// the execution-time counter.
interface exec_time_counter_if #(
  parameter int CNT_W = 32
);
  logic             config_enable;
  logic [7:0]       cmd;
  logic [15:0]      addr;
  logic [15:0]      data_write;
  logic             start;
  logic             done;
  logic [CNT_W-1:0] exec_time_cnt;
  logic             cnt_valid;
  logic             timeout;
  logic [15:0]      status_read;

  modport master (
    output config_enable, cmd, addr, data_write, start, done,
    input  exec_time_cnt, cnt_valid, timeout, status_read
  );

  modport slave (
    input  config_enable, cmd, addr, data_write, start, done,
    output exec_time_cnt, cnt_valid, timeout, status_read
  );
endinterface

// File: rtl/exec_cfg_decode.sv
// Decodes local-bus config accesses to the control word into single-cycle
// clear, software-start and status-read strobes.
module exec_cfg_decode
  import exec_cnt_pkg::*;
#(
  parameter logic [15:0] ADDR_CTRL = 16'h0007
) (
  input  logic        config_enable,
  input  logic [7:0]  cmd,
  input  logic [15:0] addr,
  input  logic [1:0]  ctrl_bits,
  output logic        clear,
  output logic        sw_start,
  output logic        status_rd
);
  logic ctrl_hit;
  logic ctrl_write;

  assign ctrl_hit   = config_enable && (addr == ADDR_CTRL);
  assign ctrl_write = ctrl_hit && (cmd == CMD_CONFIG_WRITE);

  assign clear     = ctrl_write && ctrl_bits[0];
  assign sw_start  = ctrl_write && ctrl_bits[1];
  assign status_rd = ctrl_hit && (cmd == CMD_CONFIG_READ);
endmodule

// File: rtl/exec_time_counter.sv
// Counts clk edges from a core start pulse to its done pulse and holds the
// result, with timeout abort and bus-controlled clear/start/status.
module exec_time_counter
  import exec_cnt_pkg::*;
#(
  parameter int               CNT_W          = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 32'h00FF_FFFF,
  parameter bit               AUTO_REARM     = 1'b0,
  parameter logic [15:0]      ADDR_CTRL      = 16'h0007
) (
  input logic               clk,
  input logic               rst,
  exec_time_counter_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] result;
  logic             valid;
  logic             timed_out;
  logic [15:0]      status;
  logic             clear;
  logic             sw_start;
  logic             status_rd;
  logic             go;

  exec_cfg_decode #(.ADDR_CTRL(ADDR_CTRL)) u_decode (
    .config_enable (bus.config_enable),
    .cmd           (bus.cmd),
    .addr          (bus.addr),
    .ctrl_bits     (bus.data_write[1:0]),
    .clear         (clear),
    .sw_start      (sw_start),
    .status_rd     (status_rd)
  );

  assign go       = bus.start || sw_start;
  assign run_next = run_cnt + CNT_W'(1);

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below sees the values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run_cnt   <= '0;
      result    <= '0;
      valid     <= 1'b0;
      timed_out <= 1'b0;
      status    <= '0;
    end else begin
      if (status_rd) status <= {13'b0, timed_out, valid, state == RUN};

      if (clear) begin
        state     <= IDLE;
        run_cnt   <= '0;
        result    <= '0;
        valid     <= 1'b0;
        timed_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            run_cnt <= '0;
            state   <= RUN;
          end
          RUN: begin
            // Result counts edges from start to done, so done next cycle gives 1.
            if (bus.done) begin
              result    <= run_next;
              valid     <= 1'b1;
              timed_out <= 1'b0;
              state     <= HOLD;
            end else if (run_next == TIMEOUT_CYCLES) begin
              result    <= '1;
              valid     <= 1'b1;
              timed_out <= 1'b1;
              state     <= HOLD;
            end else begin
              run_cnt <= run_next;
            end
          end
          HOLD: if (AUTO_REARM && go) begin
            run_cnt <= '0;
            state   <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.exec_time_cnt = result;
  assign bus.cnt_valid     = valid;
  assign bus.timeout       = timed_out;
  assign bus.status_read   = status;
endmodule

// File: tb/tb_exec_time_counter.sv
// Drives three counter variants with one stimulus stream and scoreboards every
// cycle against an elapsed-time model, plus anchored directed checks.
module tb_exec_time_counter;
  import exec_cnt_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] cnt;
    logic        valid;
    logic        to;
    logic [15:0] status;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [7:0]  cmd;
  logic [15:0] addr;
  logic [15:0] dw;
  logic        st;
  logic        dn;

  always #5 clk = ~clk;

  exec_time_counter_if #(.CNT_W(32)) if0 ();
  exec_time_counter_if #(.CNT_W(32)) if1 ();
  exec_time_counter_if #(.CNT_W(32)) if2 ();

  exec_time_counter #(.CNT_W(32), .TIMEOUT_CYCLES(32'd16), .AUTO_REARM(1'b0),
                      .ADDR_CTRL(ADDR_CTRL)) u0 (.clk(clk), .rst(rst), .bus(if0));
  exec_time_counter #(.CNT_W(32), .TIMEOUT_CYCLES(32'd1000), .AUTO_REARM(1'b0),
                      .ADDR_CTRL(ADDR_CTRL)) u1 (.clk(clk), .rst(rst), .bus(if1));
  exec_time_counter #(.CNT_W(32), .TIMEOUT_CYCLES(32'd1000), .AUTO_REARM(1'b1),
                      .ADDR_CTRL(ADDR_CTRL)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.config_enable = cfg_en; assign if1.config_enable = cfg_en; assign if2.config_enable = cfg_en;
  assign if0.cmd = cmd;              assign if1.cmd = cmd;              assign if2.cmd = cmd;
  assign if0.addr = addr;            assign if1.addr = addr;            assign if2.addr = addr;
  assign if0.data_write = dw;        assign if1.data_write = dw;        assign if2.data_write = dw;
  assign if0.start = st;             assign if1.start = st;             assign if2.start = st;
  assign if0.done = dn;              assign if1.done = dn;              assign if2.done = dn;

  logic [31:0] act_cnt [N];
  logic        act_valid [N];
  logic        act_to [N];
  logic [15:0] act_stat [N];
  assign act_cnt[0] = if0.exec_time_cnt; assign act_valid[0] = if0.cnt_valid;
  assign act_to[0]  = if0.timeout;       assign act_stat[0]  = if0.status_read;
  assign act_cnt[1] = if1.exec_time_cnt; assign act_valid[1] = if1.cnt_valid;
  assign act_to[1]  = if1.timeout;       assign act_stat[1]  = if1.status_read;
  assign act_cnt[2] = if2.exec_time_cnt; assign act_valid[2] = if2.cnt_valid;
  assign act_to[2]  = if2.timeout;       assign act_stat[2]  = if2.status_read;

  // Reference model: a measurement is "the edge count since the start edge".
  int unsigned to_lim [N];
  bit          rearm [N];
  bit          m_run [N];
  bit          m_hold [N];
  bit          m_valid [N];
  bit          m_to [N];
  logic [31:0] m_cnt [N];
  logic [15:0] m_stat [N];
  longint      m_start [N];
  longint      cyc = 0;

  exp_t sb [N][$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     ctrl_wr, clr, go, rd;
    longint el;
    cyc++;
    ctrl_wr = cfg_en && cmd == CMD_CONFIG_WRITE && addr == ADDR_CTRL;
    clr     = ctrl_wr && dw[0];
    go      = st || (ctrl_wr && dw[1]);
    rd      = cfg_en && cmd == CMD_CONFIG_READ && addr == ADDR_CTRL;
    for (int i = 0; i < N; i++) begin
      if (rst || clr) begin
        m_run[i] = 0; m_hold[i] = 0; m_valid[i] = 0; m_to[i] = 0; m_cnt[i] = '0;
        if (rst) m_stat[i] = '0;
        else if (rd) m_stat[i] = {13'b0, m_to[i], m_valid[i], m_run[i]};
      end else begin
        if (rd) m_stat[i] = {13'b0, m_to[i], m_valid[i], m_run[i]};
        if (m_run[i]) begin
          el = cyc - m_start[i];
          if (dn) begin
            m_cnt[i] = 32'(el); m_valid[i] = 1; m_to[i] = 0; m_run[i] = 0; m_hold[i] = 1;
          end else if (el == longint'(to_lim[i])) begin
            m_cnt[i] = 32'hFFFF_FFFF; m_valid[i] = 1; m_to[i] = 1; m_run[i] = 0; m_hold[i] = 1;
          end
        end else if (go && (!m_hold[i] || rearm[i])) begin
          m_run[i] = 1; m_hold[i] = 0; m_start[i] = cyc;
        end
      end
    end
  endtask

  task automatic step(input bit c, input logic [7:0] cm, input logic [15:0] a,
                      input logic [15:0] d, input bit s, input bit dn_i, input bit r);
    exp_t e;
    @(negedge clk);
    cfg_en = c; cmd = cm; addr = a; dw = d; st = s; dn = dn_i; rst = r;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      e.cnt = m_cnt[i]; e.valid = m_valid[i]; e.to = m_to[i]; e.status = m_stat[i];
      sb[i].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0);
  endtask
  task automatic pulse_start(); step(0, 8'h00, 16'h0000, 16'h0000, 1, 0, 0); endtask
  task automatic pulse_done();  step(0, 8'h00, 16'h0000, 16'h0000, 0, 1, 0); endtask
  task automatic wr_ctrl(input logic [15:0] d); step(1, CMD_CONFIG_WRITE, ADDR_CTRL, d, 0, 0, 0); endtask
  task automatic rd_ctrl(); step(1, CMD_CONFIG_READ, ADDR_CTRL, 16'h0000, 0, 0, 0); endtask

  // Monitor: every negedge, compare the outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          check($sformatf("u%0d_cnt", i), act_cnt[i], e.cnt);
          check($sformatf("u%0d_valid", i), 32'(act_valid[i]), 32'(e.valid));
          check($sformatf("u%0d_timeout", i), 32'(act_to[i]), 32'(e.to));
          check($sformatf("u%0d_status", i), 32'(act_stat[i]), 32'(e.status));
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    to_lim[0] = 16;   rearm[0] = 0;
    to_lim[1] = 1000; rearm[1] = 0;
    to_lim[2] = 1000; rearm[2] = 1;
    cfg_en = 0; cmd = '0; addr = '0; dw = '0; st = 0; dn = 0; rst = 1;

    step(0, 8'h00, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 8'h00, 16'h0000, 16'h0000, 0, 0, 1);
    check("reset_cnt", if1.exec_time_cnt, 32'd0);
    check("reset_status", 32'(if1.status_read), 32'd0);

    // start at cycle 10, done 100 edges later
    idle(7);
    pulse_start();
    idle(99);
    pulse_done();
    check("t1_cnt", if1.exec_time_cnt, 32'd100);
    check("t1_valid", 32'(if1.cnt_valid), 32'd1);
    check("t1_timeout", 32'(if1.timeout), 32'd0);
    rd_ctrl();
    check("t1_status_not_busy", 32'(if1.status_read), 32'h0002);
    wr_ctrl(16'h0001);

    // done on the cycle after start, then a start in HOLD without rearm
    pulse_start();
    pulse_done();
    check("t2_cnt_one", if0.exec_time_cnt, 32'd1);
    pulse_start();
    idle(3);
    check("t2_hold_ignores_start", if1.exec_time_cnt, 32'd1);
    wr_ctrl(16'h0001);

    // software start into a 16-cycle timeout
    wr_ctrl(16'h0002);
    idle(15);
    check("t3_no_timeout_yet", 32'(if0.timeout), 32'd0);
    idle(1);
    check("t3_cnt_ones", if0.exec_time_cnt, 32'hFFFF_FFFF);
    check("t3_timeout", 32'(if0.timeout), 32'd1);
    rd_ctrl();
    check("t3_status", 32'(if0.status_read), 32'h0006);
    wr_ctrl(16'h0001);

    // clear and done on the same edge: clear wins
    pulse_start();
    idle(5);
    step(1, CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001, 0, 1, 0);
    check("t4_cnt_cleared", if1.exec_time_cnt, 32'd0);
    check("t4_valid_cleared", 32'(if1.cnt_valid), 32'd0);

    // auto-rearm: old result visible through the new run
    pulse_start();
    idle(49);
    pulse_done();
    check("t5_first", if2.exec_time_cnt, 32'd50);
    pulse_start();
    idle(5);
    check("t5_held_during_run", if2.exec_time_cnt, 32'd50);
    rd_ctrl();
    check("t5_status_busy_valid", 32'(if2.status_read), 32'h0003);
    idle(13);
    pulse_done();
    check("t5_second", if2.exec_time_cnt, 32'd20);
    check("t5_no_rearm", if1.exec_time_cnt, 32'd50);
    wr_ctrl(16'h0001);

    // reset mid-run discards the measurement
    pulse_start();
    idle(10);
    step(0, 8'h00, 16'h0000, 16'h0000, 0, 0, 1);
    pulse_done();
    check("t6_cnt", if1.exec_time_cnt, 32'd0);
    check("t6_valid", 32'(if1.cnt_valid), 32'd0);
    rd_ctrl();
    check("t6_status_idle", 32'(if1.status_read), 32'h0000);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 3))
        0: ra = ADDR_CNT0;
        1: ra = ADDR_CNT1;
        2: ra = ADDR_CTRL;
        default: ra = 16'h0008;
      endcase
      step($urandom_range(0, 29) == 0, 8'($urandom_range(0, 3)), ra,
           16'($urandom_range(0, 3)), $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 499) == 0);
    end

    idle(1);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        errors++;
        $display("FAIL u%0d_drain: %0d entries left, expected 0", i, sb[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
